// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer
// Turns a stream of 32-bit configuration words into row-by-row frame writes.
// The word stream syncs on SyncWord. Each header loads the frame address and
// optionally announces a multi-frame burst. Data words are streamed one row
// at a time. An optional XOR checksum closes each header's frames. Every
// completed frame fires a LongFrameStrobe pulse that is StrobeLength cycles
// long, and FrameCount records the number of frames committed.
module config_frame_sequencer #(
  parameter int          NumberOfRows    = 16,
  parameter int          RowSelectWidth  = 5,
  parameter int          FrameBitsPerRow = 32,
  parameter logic [31:0] SyncWord        = 32'hFAB0FAB1,
  parameter int          DesyncFlag      = 20,
  parameter int          BurstFlag       = 21,
  parameter bit          ChecksumEnable  = 1'b1,
  parameter int          StrobeLength    = 2
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [31:0]                WriteData,
  input  logic                       WriteStrobe,
  output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
  output logic                       LongFrameStrobe,
  output logic [RowSelectWidth-1:0]  RowSelect,
  output logic                       Synced,
  output logic                       ConfigError,
  output logic [15:0]                FrameCount
);

  // The strobe counter holds the number of high cycles still owed after the
  // current one, so its largest value is StrobeLength-1.
  localparam int StrobeCntW = (StrobeLength > 1) ? $clog2(StrobeLength) : 1;

  localparam logic [RowSelectWidth-1:0]  RowsInit     = RowSelectWidth'(NumberOfRows);
  localparam logic [RowSelectWidth-1:0]  RowLast      = RowSelectWidth'(1);
  localparam logic [RowSelectWidth-1:0]  RowNone      = {RowSelectWidth{1'b1}};
  localparam logic [StrobeCntW-1:0]      StrobeReload = StrobeCntW'(StrobeLength - 1);
  localparam logic [FrameBitsPerRow-1:0] AddrStep     = FrameBitsPerRow'(1);

  typedef enum logic [2:0] {
    UNSYNC,
    HEADER,
    COUNT,
    DATA,
    CHECK
  } state_t;

  state_t                    state;
  logic [RowSelectWidth-1:0] row_cnt;
  logic [15:0]               remaining;
  logic [31:0]               acc;
  logic [StrobeCntW-1:0]     strobe_cnt;
  logic                      commit;

  // This counter saturates at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end
    return value + 16'd1;
  endfunction

  // A burst length of zero is treated as a single frame.
  function automatic logic [15:0] burst_frames(input logic [15:0] field);
    if (field == 16'd0) begin
      return 16'd1;
    end
    return field;
  endfunction

  // The row indication is only meaningful while a data word is on the bus.
  always_comb begin
    RowSelect = RowNone;
    if (state == DATA && WriteStrobe) begin
      RowSelect = row_cnt;
    end
  end

  // A frame is committed on the accepting edge of its last row word.
  always_comb begin
    commit = 1'b0;
    if (state == DATA && WriteStrobe && row_cnt == RowLast) begin
      commit = 1'b1;
    end
  end

  // Word-driven sequencer: sync, header, burst count, row data and checksum.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state                <= UNSYNC;
      Synced               <= 1'b0;
      ConfigError          <= 1'b0;
      FrameAddressRegister <= '0;
      row_cnt              <= '0;
      remaining            <= '0;
      acc                  <= '0;
      FrameCount           <= '0;
    end else if (WriteStrobe) begin
      case (state)
        UNSYNC: begin
          if (WriteData == SyncWord) begin
            state       <= HEADER;
            Synced      <= 1'b1;
            ConfigError <= 1'b0;
          end
        end

        HEADER: begin
          // The desync bit takes priority over the burst bit in the same header.
          if (WriteData[DesyncFlag]) begin
            state  <= UNSYNC;
            Synced <= 1'b0;
          end else begin
            FrameAddressRegister <= WriteData[FrameBitsPerRow-1:0];
            row_cnt              <= RowsInit;
            acc                  <= '0;
            if (WriteData[BurstFlag]) begin
              state <= COUNT;
            end else begin
              remaining <= 16'd1;
              state     <= DATA;
            end
          end
        end

        COUNT: begin
          remaining <= burst_frames(WriteData[15:0]);
          row_cnt   <= RowsInit;
          state     <= DATA;
        end

        DATA: begin
          acc <= acc ^ WriteData;
          if (row_cnt == RowLast) begin
            FrameCount <= sat_inc16(FrameCount);
            remaining  <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= ChecksumEnable ? CHECK : HEADER;
            end else begin
              // Later frames of a burst land on consecutive addresses, and
              // the address wraps around at the register width.
              FrameAddressRegister <= FrameAddressRegister + AddrStep;
              row_cnt              <= RowsInit;
            end
          end else begin
            row_cnt <= row_cnt - RowLast;
          end
        end

        CHECK: begin
          if (WriteData == acc) begin
            state <= HEADER;
          end else begin
            ConfigError <= 1'b1;
            Synced      <= 1'b0;
            state       <= UNSYNC;
          end
        end

        default: begin
          state  <= UNSYNC;
          Synced <= 1'b0;
        end
      endcase
    end
  end

  // Stretch each commit into a StrobeLength pulse. A commit that arrives
  // while the pulse is still high reloads the count, so the pulse is
  // extended rather than dropped.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      LongFrameStrobe <= 1'b0;
      strobe_cnt      <= '0;
    end else if (commit) begin
      LongFrameStrobe <= 1'b1;
      strobe_cnt      <= StrobeReload;
    end else if (strobe_cnt != '0) begin
      strobe_cnt <= strobe_cnt - StrobeCntW'(1);
    end else begin
      LongFrameStrobe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Testbench for config_frame_sequencer.
// Word streams are generated from sessions made of sync, header, optional
// burst count, row data, checksum and desync words. The expected outputs come
// from the structure of those sessions: the expected row of each word, the
// address of each frame, when each commit happens, the XOR over the data
// words, and the running frame total. FrameBitsPerRow is 20, which puts the
// header flag bits above the address field.
module tb_config_frame_sequencer;

  localparam int          ROWS = 16;
  localparam int          RSW  = 5;
  localparam int          FBPR = 20;
  localparam int          SLEN = 2;
  localparam logic [31:0] SYNC = 32'hFAB0FAB1;
  localparam logic [RSW-1:0] ROW_NONE = {RSW{1'b1}};

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     wdata;
  logic            wstrb;
  logic [FBPR-1:0] far;
  logic            strobe;
  logic [RSW-1:0]  rowsel;
  logic            synced;
  logic            cfg_err;
  logic [15:0]     fcount;

  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  int              commit_edge = -1000;
  bit              mon_en = 1'b0;
  bit              gaps = 1'b0;
  int              exp_fc = 0;
  logic [FBPR-1:0] exp_far = '0;
  logic [31:0]     acc_m = '0;

  config_frame_sequencer #(
    .NumberOfRows   (ROWS),
    .RowSelectWidth (RSW),
    .FrameBitsPerRow(FBPR),
    .SyncWord       (SYNC),
    .DesyncFlag     (20),
    .BurstFlag      (21),
    .ChecksumEnable (1'b1),
    .StrobeLength   (SLEN)
  ) dut (
    .CLK                 (clk),
    .Reset               (rst),
    .WriteData           (wdata),
    .WriteStrobe         (wstrb),
    .FrameAddressRegister(far),
    .LongFrameStrobe     (strobe),
    .RowSelect           (rowsel),
    .Synced              (synced),
    .ConfigError         (cfg_err),
    .FrameCount          (fcount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endfunction

  // The strobe must be high during the SLEN cycles that start at the most recent commit edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("strobe", {63'd0, strobe},
            {63'd0, ((cyc - commit_edge) >= 0) && ((cyc - commit_edge) < SLEN)});
    end
  end

  task automatic idle();
    wstrb = 1'b0;
    wdata = $urandom;
    @(negedge clk);
    check("row_gap", {59'd0, rowsel}, {59'd0, ROW_NONE});
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input int row, input bit last);
    logic [RSW-1:0] er;
    if (gaps) repeat ($urandom_range(0, 2)) idle();
    er = (row < 0) ? ROW_NONE : RSW'(row);
    wdata = w;
    wstrb = 1'b1;
    @(negedge clk);
    check("rowsel", {59'd0, rowsel}, {59'd0, er});
    @(posedge clk);
    #1;
    wstrb = 1'b0;
    if (last) begin
      commit_edge = cyc;
      if (exp_fc < 65535) exp_fc++;
      check("fcount", {48'd0, fcount}, 64'(exp_fc));
    end
  endtask

  task automatic check_status(input bit s, input bit e);
    check("synced", {63'd0, synced}, {63'd0, s});
    check("cfg_err", {63'd0, cfg_err}, {63'd0, e});
  endtask

  task automatic do_sync();
    send(SYNC, -1, 1'b0);
    check_status(1'b1, 1'b0);
  endtask

  task automatic do_garbage();
    logic [31:0] w;
    w = $urandom;
    if (w == SYNC) w = w ^ 32'h1;
    send(w, -1, 1'b0);
    check("synced_ign", {63'd0, synced}, 64'd0);
  endtask

  task automatic do_desync();
    logic [31:0] h;
    h = $urandom;
    h[20] = 1'b1;
    send(h, -1, 1'b0);
    check("synced_ds", {63'd0, synced}, 64'd0);
    check("far_hold", {44'd0, far}, {44'd0, exp_far});
  endtask

  task automatic send_frames(input int nfr);
    logic [31:0] d;
    for (int f = 0; f < nfr; f++) begin
      check("far", {44'd0, far}, {44'd0, exp_far});
      for (int r = ROWS; r >= 1; r--) begin
        d = $urandom;
        acc_m = acc_m ^ d;
        send(d, r, r == 1);
      end
      if (f < nfr - 1) exp_far = exp_far + 1'b1;
    end
  endtask

  // burst < 0: single frame; otherwise burst is the 16-bit count field
  task automatic do_header(input logic [FBPR-1:0] a, input int burst, input bit corrupt);
    logic [31:0] hdr;
    logic [31:0] cw;
    logic [31:0] ck;
    int nfr;
    hdr = $urandom;
    hdr[20] = 1'b0;
    hdr[21] = (burst >= 0);
    hdr[FBPR-1:0] = a;
    send(hdr, -1, 1'b0);
    exp_far = a;
    check("far_hdr", {44'd0, far}, {44'd0, exp_far});
    check("synced_hdr", {63'd0, synced}, 64'd1);
    nfr = 1;
    if (burst >= 0) begin
      cw = $urandom;
      cw[15:0] = 16'(burst);
      send(cw, -1, 1'b0);
      nfr = (burst == 0) ? 1 : burst;
    end
    acc_m = '0;
    send_frames(nfr);
    ck = acc_m;
    if (corrupt) ck = ck ^ (32'h1 << $urandom_range(0, 31));
    send(ck, -1, 1'b0);
    if (corrupt) check_status(1'b0, 1'b1);
    else check_status(1'b1, 1'b0);
    check("far_end", {44'd0, far}, {44'd0, exp_far});
  endtask

  initial begin
    bit bad;
    rst = 1'b1;
    wstrb = 1'b0;
    wdata = '0;
    #1;
    check("rst_far", {44'd0, far}, 64'd0);
    check("rst_strobe", {63'd0, strobe}, 64'd0);
    check("rst_row", {59'd0, rowsel}, {59'd0, ROW_NONE});
    check("rst_fc", {48'd0, fcount}, 64'd0);
    check_status(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // T1 single frame
    do_sync();
    do_header(20'h00005, -1, 1'b0);
    // T2 burst of three
    do_header(20'h00010, 3, 1'b0);
    // T3 bad checksum, then resync clears the error
    do_header(20'h00005, -1, 1'b1);
    do_garbage();
    check("cfg_err_sticky", {63'd0, cfg_err}, 64'd1);
    do_sync();
    // T4 desync, further words ignored
    do_desync();
    repeat (3) do_garbage();
    // T5 gaps and address wrap
    gaps = 1'b1;
    do_sync();
    do_header(20'hFFFFF, 2, 1'b0);
    do_desync();
    gaps = 1'b0;
    // T6 reset mid-frame
    do_sync();
    send(32'h0000_0007, -1, 1'b0);
    for (int r = ROWS; r > ROWS - 7; r--) send($urandom, r, 1'b0);
    wdata = $urandom;
    wstrb = 1'b1;
    rst = 1'b1;
    commit_edge = -1000;
    exp_fc = 0;
    exp_far = '0;
    #1;
    check("mid_rst_far", {44'd0, far}, 64'd0);
    check("mid_rst_strobe", {63'd0, strobe}, 64'd0);
    check("mid_rst_row", {59'd0, rowsel}, {59'd0, ROW_NONE});
    check("mid_rst_fc", {48'd0, fcount}, 64'd0);
    check_status(1'b0, 1'b0);
    @(posedge clk);
    #1;
    wstrb = 1'b0;
    rst = 1'b0;
    do_sync();
    do_header(20'h00005, -1, 1'b0);
    do_desync();

    // randomized sessions
    for (int s = 0; s < 25; s++) begin
      gaps = bit'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) do_garbage();
      do_sync();
      bad = 1'b0;
      for (int h = 0; h < int'($urandom_range(1, 3)) && !bad; h++) begin
        bad = ($urandom_range(0, 5) == 0);
        do_header(FBPR'($urandom),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
                  bad);
      end
      if (!bad) do_desync();
    end
    gaps = 1'b0;
    repeat (4) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

endmodule
